// File: rtl/dcatch_pkg.sv
// Shared definitions for the data-RAM load/store sequencer.
//   - DCatchDepth : default byte-address width
//   - F3_*        : RV32 load/store size/sign codes
//   - state_e     : sequencer FSM states
//   - size_mask() : byte-lane footprint of an access before offset shift
//   - funct3_legal(): legality of a funct3 code for a load or a store
package dcatch_pkg;

    localparam int DCatchDepth = 12;

    // Load codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Store codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE0  = 3'd1,
        ST_ISSUE1  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Low two bits of funct3 encode the size for both loads and stores.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dcatch_align.sv
// Combinational lane alignment for the data-RAM sequencer.
//   funct3_i  : size/sign code of the access
//   off_i     : byte offset within the word (addr[1:0])
//   wdata_i   : right-justified store data
//   buf_i     : 64-bit assembled read buffer (phase 0 in [31:0], phase 1 in [63:32])
//   mask7_o   : byte-lane footprint across two consecutive words
//   wdata64_o : store data shifted onto its lanes across two words
//   rdata_o   : load result extracted from buf_i and sign/zero extended
module dcatch_align
    import dcatch_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] buf_i,
    output logic [6:0]  mask7_o,
    output logic [63:0] wdata64_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  byte_shift;
    logic [31:0] x;

    always_comb begin
        byte_shift = {off_i, 3'b000};
        mask7_o    = {3'b000, size_mask(funct3_i)} << off_i;
        wdata64_o  = {32'b0, wdata_i} << byte_shift;
        // Bytes of interest start at the offset; the upper word of buf only
        // contributes when the access straddled a word boundary.
        x          = 32'(buf_i >> byte_shift);
        case (funct3_i)
            F3_LB:   rdata_o = {{24{x[7]}}, x[7:0]};
            F3_LBU:  rdata_o = {24'b0, x[7:0]};
            F3_LH:   rdata_o = {{16{x[15]}}, x[15:0]};
            F3_LHU:  rdata_o = {16'b0, x[15:0]};
            F3_LW:   rdata_o = x;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/dcatch_ctrl.sv
// Load/store sequencer between the memory stage and a four-lane byte RAM.
// Accepts one byte-addressed request at a time, splits word-crossing
// accesses into two RAM cycles, and returns extended load data on a
// valid/ready response channel.
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake (ready only when idle)
//   req_we/funct3/addr/wdata  : request fields
//   resp_valid/resp_ready     : response handshake
//   resp_rdata/resp_err       : load result (0 for stores/errors), illegal funct3
//   ram_addr/wren/wrdata/rden : RAM port, driven from the current state
//   ram_rddata                : RAM read data, one cycle after ram_rden
module dcatch_ctrl
    import dcatch_pkg::*;
#(
    parameter int ADDR_W    = DCatchDepth,
    parameter int RAM_DEPTH = ADDR_W - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [RAM_DEPTH-1:0] ram_addr,
    output logic [3:0]           ram_wren,
    output logic [31:0]          ram_wrdata,
    output logic [3:0]           ram_rden,
    input  logic [31:0]          ram_rddata
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [63:0]         buf_q, buf_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [6:0]          mask7;
    logic [63:0]         wdata64;
    logic [31:0]         ext_rdata;
    logic [RAM_DEPTH-1:0] word;
    logic                split;
    logic [3:0]          lanes;

    assign word  = addr_q[ADDR_W-1:2];
    assign split = |mask7[6:4];

    // The extractor sees the buffer as it will be after this cycle's
    // capture, so the final result can be registered on the way into RESP.
    dcatch_align u_align (
        .funct3_i  (funct3_q),
        .off_i     (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .buf_i     (buf_d),
        .mask7_o   (mask7),
        .wdata64_o (wdata64),
        .rdata_o   (ext_rdata)
    );

    // Read-buffer capture, kept apart from the FSM block so the extractor
    // output never feeds back into the process that produces its input.
    always_comb begin
        buf_d = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) buf_d = '0;
            end
            ST_ISSUE1: begin
                if (!we_q) buf_d[31:0] = ram_rddata;
            end
            ST_CAPTURE: begin
                if (split) buf_d[63:32] = ram_rddata;
                else       buf_d[31:0]  = ram_rddata;
            end
            default: ;
        endcase
    end

    // NOTE: every output of a combinational block is given a default before
    // the case statement; a path that skips an assignment would infer a latch.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_addr   = '0;
        ram_wren   = '0;
        ram_rden   = '0;
        ram_wrdata = '0;
        lanes      = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = !funct3_legal(req_we, req_funct3);
                    // Illegal requests skip the RAM entirely.
                    state_d  = err_d ? ST_RESP : ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                lanes      = mask7[3:0];
                ram_addr   = word;
                ram_wrdata = wdata64[31:0];
                if (we_q) ram_wren = lanes;
                else      ram_rden = lanes;
                if (split)     state_d = ST_ISSUE1;
                else if (we_q) state_d = ST_RESP;
                else           state_d = ST_CAPTURE;
            end
            ST_ISSUE1: begin
                lanes      = {1'b0, mask7[6:4]};
                // Wraps past the top of the RAM back to word 0.
                ram_addr   = word + RAM_DEPTH'(1);
                ram_wrdata = wdata64[63:32];
                if (we_q) ram_wren = lanes;
                else      ram_rden = lanes;
                state_d = we_q ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rdata_d = ext_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dcatch_ctrl.sv
// Self-checking bench for dcatch_ctrl: directed scenarios followed by
// randomized loads/stores compared against a flat byte-array memory model.
module tb_dcatch_ctrl;

    localparam int ADDR_W    = 12;
    localparam int RAM_DEPTH = ADDR_W - 2;
    localparam int NBYTES    = 1 << ADDR_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_we = 1'b0;
    logic [2:0]           req_funct3 = '0;
    logic [ADDR_W-1:0]    req_addr = '0;
    logic [31:0]          req_wdata = '0;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic [RAM_DEPTH-1:0] ram_addr;
    logic [3:0]           ram_wren;
    logic [31:0]          ram_wrdata;
    logic [3:0]           ram_rden;
    logic [31:0]          ram_rddata = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Physical RAM the DUT talks to, and the independent byte-level model.
    logic [31:0] ram_mem [1 << RAM_DEPTH];
    logic [7:0]  ref_mem [NBYTES];

    // Observations from the most recent transaction.
    logic [RAM_DEPTH-1:0] c1_addr, c2_addr;
    logic [3:0]           c1_wren, c1_rden, c2_wren, c2_rden;
    logic [31:0]          c1_wrdata, c2_wrdata;
    logic [31:0]          last_rdata;
    logic                 last_err;

    dcatch_ctrl #(.ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_wren   (ram_wren),
        .ram_wrdata (ram_wrdata),
        .ram_rden   (ram_rden),
        .ram_rddata (ram_rddata)
    );

    always #5 clk = ~clk;

    // Byte-lane RAM with a one-cycle registered read; unread lanes return junk.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (ram_wren[l]) ram_mem[ram_addr][8*l +: 8] <= ram_wrdata[8*l +: 8];
            ram_rddata[8*l +: 8] <= ram_rden[l] ? ram_mem[ram_addr][8*l +: 8] : 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int f3_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_legal(input bit we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [ADDR_W-1:0] addr);
        logic [31:0] v;
        logic [ADDR_W-1:0] a;
        v = '0;
        for (int i = 0; i < f3_size(f3); i++) begin
            a = addr + ADDR_W'(i);
            v = v | (32'(ref_mem[a]) << (8 * i));
        end
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // One complete transaction: drive, observe RAM traffic, check the
    // response, optionally stall the response while poking a stray request.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wd, input int hold);
        bit          exp_err;
        int          size, exp_lat, lat, n_en, n_bad, n_dir, n_both;
        logic [31:0] exp_rdata, wd_shift;
        logic [ADDR_W-1:0] ba, d, a;

        exp_err   = !is_legal(we, f3);
        size      = exp_err ? 0 : f3_size(f3);
        exp_lat   = exp_err ? 1 : (we ? 2 : 3) + ((int'(addr[1:0]) + size > 4) ? 1 : 0);
        exp_rdata = (!exp_err && !we) ? model_load(f3, addr) : 32'h0;
        if (!exp_err && we) begin
            for (int i = 0; i < size; i++) begin
                a = addr + ADDR_W'(i);
                wd_shift = wd >> (8 * i);
                ref_mem[a] = wd_shift[7:0];
            end
        end

        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = ADDR_W'($urandom);
        req_wdata  = $urandom;

        lat = 1; n_en = 0; n_bad = 0; n_dir = 0; n_both = 0;
        c1_addr = '0; c1_wren = '0; c1_rden = '0; c1_wrdata = '0;
        c2_addr = '0; c2_wren = '0; c2_rden = '0; c2_wrdata = '0;
        while (!resp_valid && lat < 12) begin
            if (lat == 1) begin
                c1_addr = ram_addr; c1_wren = ram_wren; c1_rden = ram_rden; c1_wrdata = ram_wrdata;
            end else if (lat == 2) begin
                c2_addr = ram_addr; c2_wren = ram_wren; c2_rden = ram_rden; c2_wrdata = ram_wrdata;
            end
            if (ram_wren != 0 && ram_rden != 0) n_both++;
            if (we && ram_rden != 0) n_dir++;
            if (!we && ram_wren != 0) n_dir++;
            for (int l = 0; l < 4; l++) begin
                if (ram_wren[l] || ram_rden[l]) begin
                    n_en++;
                    ba = {ram_addr, 2'(l)};
                    d  = ba - addr;
                    if (int'(d) >= size) n_bad++;
                    else if (ram_wren[l]) begin
                        wd_shift = wd >> (8 * int'(d));
                        if (ram_wrdata[8*l +: 8] != wd_shift[7:0]) n_bad++;
                    end
                end
            end
            @(negedge clk);
            lat++;
        end

        check("latency", lat, exp_lat);
        check("lanes_enabled", n_en, size);
        check("lanes_outside_or_data", n_bad, 0);
        check("wren_rden_direction", n_dir + n_both, 0);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", resp_err, exp_err);
        last_rdata = resp_rdata;
        last_err   = resp_err;

        for (int h = 0; h < hold; h++) begin
            // Stray store that must be ignored while the response is pending.
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = ADDR_W'(12'h100);
            req_wdata  = 32'hCAFE_F00D;
            @(negedge clk);
            check("hold_resp_valid", resp_valid, 1'b1);
            check("hold_resp_rdata", resp_rdata, exp_rdata);
            check("hold_resp_err", resp_err, exp_err);
            check("hold_req_ready", req_ready, 1'b0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_consumed", resp_valid, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << RAM_DEPTH); i++) ram_mem[i] = '0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = '0;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_ram_en", {ram_wren, ram_rden}, 8'h0);
        check("rst_ram_addr", ram_addr, '0);
        check("rst_ram_wrdata", ram_wrdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned store, then reads of that word
        do_req(1'b1, 3'b010, 12'h004, 32'hDEAD_BEEF, 0);
        check("sw_c1_addr", c1_addr, 10'd1);
        check("sw_c1_wren", c1_wren, 4'b1111);
        check("sw_c1_wrdata", c1_wrdata, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 12'h004, 32'h0, 0);
        check("lw_value", last_rdata, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b000, 12'h007, 32'h0, 0);
        check("lb_value", last_rdata, 32'hFFFF_FFDE);
        do_req(1'b0, 3'b100, 12'h007, 32'h0, 0);
        check("lbu_value", last_rdata, 32'h0000_00DE);
        do_req(1'b0, 3'b001, 12'h006, 32'h0, 0);
        check("lh_value", last_rdata, 32'hFFFF_DEAD);

        // Split halfword store and read-back
        do_req(1'b1, 3'b001, 12'h00B, 32'h0000_1234, 0);
        check("sh_c1_addr", c1_addr, 10'd2);
        check("sh_c1_wren", c1_wren, 4'b1000);
        check("sh_c1_byte", c1_wrdata[31:24], 8'h34);
        check("sh_c2_addr", c2_addr, 10'd3);
        check("sh_c2_wren", c2_wren, 4'b0001);
        check("sh_c2_byte", c2_wrdata[7:0], 8'h12);
        do_req(1'b0, 3'b101, 12'h00B, 32'h0, 0);
        check("lhu_split_value", last_rdata, 32'h0000_1234);

        // Word load wrapping past the top of memory
        do_req(1'b1, 3'b010, 12'hFFC, 32'hAABB_CCDD, 0);
        do_req(1'b1, 3'b010, 12'h000, 32'h1122_3344, 0);
        do_req(1'b0, 3'b010, 12'hFFF, 32'h0, 0);
        check("wrap_c1_addr", c1_addr, 10'h3FF);
        check("wrap_c1_rden", c1_rden, 4'b1000);
        check("wrap_c2_addr", c2_addr, 10'h000);
        check("wrap_c2_rden", c2_rden, 4'b0111);
        check("wrap_value", last_rdata, 32'h2233_44AA);

        // Illegal codes
        do_req(1'b0, 3'b011, 12'h010, 32'h0, 0);
        check("ill_load_err", last_err, 1'b1);
        do_req(1'b1, 3'b100, 12'h010, 32'h5A5A_5A5A, 0);
        check("ill_store_err", last_err, 1'b1);
        check("ill_store_rdata", last_rdata, 32'h0);

        // Stalled response with a stray request that must not take effect
        do_req(1'b0, 3'b010, 12'h004, 32'h0, 5);
        do_req(1'b0, 3'b010, 12'h100, 32'h0, 0);
        check("stray_not_written", last_rdata, 32'h0);

        // Reset during the second phase of a split store
        @(negedge clk);
        check("rst_test_ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 12'h01E;
        req_wdata  = 32'h5566_7788;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_test_issue0_wren", ram_wren, 4'b1100);
        @(negedge clk);
        check("rst_test_issue1_wren", ram_wren, 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wren", ram_wren, 4'b0000);
        check("rst_mid_ready", req_ready, 1'b1);
        check("rst_mid_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[12'h01E] = 8'h88;
        ref_mem[12'h01F] = 8'h77;
        do_req(1'b0, 3'b010, 12'h01C, 32'h0, 0);
        check("rst_phase0_kept", last_rdata[31:16], 16'h7788);
        do_req(1'b0, 3'b101, 12'h020, 32'h0, 0);
        check("rst_phase1_absent", last_rdata, 32'h0);

        // Randomized traffic over two small windows, including the wrap region
        for (int n = 0; n < 300; n++) begin
            logic [ADDR_W-1:0] ra;
            ra = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 63))
                                             : ADDR_W'($urandom_range(4064, 4095));
            do_req(1'($urandom), 3'($urandom), ra, $urandom,
                   ($urandom_range(0, 9) == 0) ? 2 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
